skewed_operand_feeder: RTL and testbench

// Fetches A and B operand vectors from the shared input memory and feeds them to a MAC_SIZE x MAC_SIZE systolic array.

---
 rtl/skewed_operand_feeder_pkg.sv | 27 ++
 rtl/skewed_operand_feeder_skew_delay_line.sv | 45 ++++
 rtl/skewed_operand_feeder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_skewed_operand_feeder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skewed_operand_feeder_pkg.sv
// Shared types and helpers for the skewed operand feeder: FSM states, geometry helpers
// and the lane-slice macro (lane 0 occupies the most significant element).
`define IN_FEED_LANE(idx, n, w) (((n) - 1 - (idx)) * (w)) +: (w)

package in_feed_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_LAND,
        S_ISSUE,
        S_FLUSH,
        S_DRAIN,
        S_COPY,
        S_DONE
    } feed_state_e;

    function automatic int calc_wpv(input int mac_size, input int elem_w, input int mem_data_w);
        return (mac_size * elem_w) / mem_data_w;
    endfunction

    function automatic int calc_tiles(input int big_mac_size, input int mac_size);
        return big_mac_size / mac_size;
    endfunction

endpackage

// File: rtl/skewed_operand_feeder_skew_delay_line.sv
// Per-lane skew: lane i is delayed by i accepted beats, lane 0 passes straight through.
// Every delay stage advances only when the downstream array takes a beat.
module skew_delay_line
    import in_feed_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter int MAC_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         shift,
    input  logic [MAC_SIZE*ELEM_W-1:0]   in_vec,
    output logic [MAC_SIZE*ELEM_W-1:0]   out_vec
);

    for (genvar i = 0; i < MAC_SIZE; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign out_vec[`IN_FEED_LANE(i, MAC_SIZE, ELEM_W)] = in_vec[`IN_FEED_LANE(i, MAC_SIZE, ELEM_W)];
        end else begin : g_dly
            localparam int DW = i * ELEM_W;

            // Newest element enters at the LSBs; the oldest sits at the top and drives the lane.
            logic [DW-1:0] pipe_q;
            logic [DW-1:0] pipe_d;

            always_comb begin
                pipe_d = pipe_q;
                if (shift) begin
                    pipe_d = (pipe_q << ELEM_W) | DW'(in_vec[`IN_FEED_LANE(i, MAC_SIZE, ELEM_W)]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign out_vec[`IN_FEED_LANE(i, MAC_SIZE, ELEM_W)] = pipe_q[DW-1 -: ELEM_W];
        end
    end

endmodule

// File: rtl/skewed_operand_feeder.sv
// Fetches A/B operand vectors from shared memory, stages them and issues them skewed to a
// MAC_SIZE x MAC_SIZE systolic array, tiling a BIG_MAC_SIZE^2 product with a copy pulse per tile.
module skewed_operand_feeder
    import in_feed_pkg::*;
#(
    parameter int ELEM_W       = 8,
    parameter int MAC_SIZE     = 32,
    parameter int BIG_MAC_SIZE = 512,
    parameter int MEM_DATA_W   = 64,
    parameter int ADDR_W       = 23,
    parameter int B_BASE_ADDR  = 1 << 15,
    parameter int DRAIN_CYCLES = MAC_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [MEM_DATA_W-1:0]        mem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MAC_SIZE*ELEM_W-1:0]   a_out,
    output logic [MAC_SIZE*ELEM_W-1:0]   b_out,
    output logic                         out_last,
    output logic                         copy_enb
);

    localparam int VEC_W = MAC_SIZE * ELEM_W;
    localparam int WPV   = calc_wpv(MAC_SIZE, ELEM_W, MEM_DATA_W);
    localparam int TILES = calc_tiles(BIG_MAC_SIZE, MAC_SIZE);
    localparam int K_W   = $clog2(BIG_MAC_SIZE) + 1;
    localparam int T_W   = $clog2(TILES) + 1;
    localparam int W_W   = $clog2(WPV) + 1;
    localparam int F_W   = $clog2(MAC_SIZE) + 1;
    localparam int D_W   = $clog2(DRAIN_CYCLES + 1) + 1;

    localparam logic [K_W-1:0] K_LAST = K_W'(BIG_MAC_SIZE - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TILES - 1);
    localparam logic [W_W-1:0] W_LAST = W_W'(WPV - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'((MAC_SIZE > 1) ? MAC_SIZE - 2 : 0);
    localparam logic [D_W-1:0] D_LAST = D_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    feed_state_e       state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [W_W-1:0]    w_q, w_d;
    logic [T_W-1:0]    row_q, row_d;
    logic [T_W-1:0]    col_q, col_d;
    logic [F_W-1:0]    fcnt_q, fcnt_d;
    logic [D_W-1:0]    dcnt_q, dcnt_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic              rd_dly_q, rd_dly_d;
    logic              selb_dly_q, selb_dly_d;
    logic [W_W-1:0]    w_dly_q, w_dly_d;

    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [VEC_W-1:0]  a_stage;
    logic [VEC_W-1:0]  b_stage;
    logic [VEC_W-1:0]  a_skew_in;
    logic [VEC_W-1:0]  b_skew_in;
    logic              shift;

    assign addr_a = (ADDR_W'(row_q) * ADDR_W'(BIG_MAC_SIZE) + ADDR_W'(k_q)) * ADDR_W'(WPV)
                    + ADDR_W'(w_q);
    assign addr_b = ADDR_W'(B_BASE_ADDR)
                    + (ADDR_W'(col_q) * ADDR_W'(BIG_MAC_SIZE) + ADDR_W'(k_q)) * ADDR_W'(WPV)
                    + ADDR_W'(w_q);

    // Read data arrives one cycle after the strobe, so the word index and A/B select
    // travel one cycle behind the request.
    for (genvar w = 0; w < WPV; w++) begin : g_stage
        logic [MEM_DATA_W-1:0] a_word_q, a_word_d;
        logic [MEM_DATA_W-1:0] b_word_q, b_word_d;

        always_comb begin
            a_word_d = a_word_q;
            b_word_d = b_word_q;
            if (rd_dly_q && (w_dly_q == W_W'(w))) begin
                if (selb_dly_q) begin
                    b_word_d = mem_rdata;
                end else begin
                    a_word_d = mem_rdata;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_word_q <= '0;
                b_word_q <= '0;
            end else begin
                a_word_q <= a_word_d;
                b_word_q <= b_word_d;
            end
        end

        assign a_stage[MEM_DATA_W*(WPV-1-w) +: MEM_DATA_W] = a_word_q;
        assign b_stage[MEM_DATA_W*(WPV-1-w) +: MEM_DATA_W] = b_word_q;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        w_d       = w_q;
        row_d     = row_q;
        col_d     = col_q;
        fcnt_d    = fcnt_q;
        dcnt_d    = dcnt_q;
        mem_rd_en = 1'b0;
        mem_addr  = addr_hold_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        copy_enb  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH_A;
                    k_d     = '0;
                    w_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FETCH_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_a;
                if (w_q == W_LAST) begin
                    w_d     = '0;
                    state_d = S_FETCH_B;
                end else begin
                    w_d = w_q + W_W'(1);
                end
            end
            S_FETCH_B: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_b;
                if (w_q == W_LAST) begin
                    w_d     = '0;
                    state_d = S_LAND;
                end else begin
                    w_d = w_q + W_W'(1);
                end
            end
            S_LAND: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                out_valid = 1'b1;
                // A single-lane array has no flush beats, so the last K step closes the tile.
                if (MAC_SIZE == 1) begin
                    out_last = (k_q == K_LAST);
                end
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        fcnt_d = '0;
                        dcnt_d = '0;
                        if (MAC_SIZE > 1) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_COPY;
                        end
                    end else begin
                        k_d     = k_q + K_W'(1);
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_FLUSH: begin
                out_valid = 1'b1;
                out_last  = (fcnt_q == F_LAST);
                if (out_ready) begin
                    if (fcnt_q == F_LAST) begin
                        dcnt_d  = '0;
                        state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_COPY;
                    end else begin
                        fcnt_d = fcnt_q + F_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    state_d = S_COPY;
                end else begin
                    dcnt_d = dcnt_q + D_W'(1);
                end
            end
            S_COPY: begin
                copy_enb = 1'b1;
                k_d      = '0;
                w_d      = '0;
                if (col_q == T_LAST) begin
                    col_d = '0;
                    if (row_q == T_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + T_W'(1);
                        state_d = S_FETCH_A;
                    end
                end else begin
                    col_d   = col_q + T_W'(1);
                    state_d = S_FETCH_A;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                row_d   = '0;
                col_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        addr_hold_d = mem_rd_en ? mem_addr : addr_hold_q;
        rd_dly_d    = mem_rd_en;
        selb_dly_d  = (state_q == S_FETCH_B);
        w_dly_d     = w_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            w_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            addr_hold_q <= '0;
            rd_dly_q    <= 1'b0;
            selb_dly_q  <= 1'b0;
            w_dly_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            w_q         <= w_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            addr_hold_q <= addr_hold_d;
            rd_dly_q    <= rd_dly_d;
            selb_dly_q  <= selb_dly_d;
            w_dly_q     <= w_dly_d;
        end
    end

    // Flush beats push zeros so the tail of every lane empties before the next tile.
    assign a_skew_in = (state_q == S_ISSUE) ? a_stage : '0;
    assign b_skew_in = (state_q == S_ISSUE) ? b_stage : '0;
    assign shift     = out_valid && out_ready;

    skew_delay_line #(
        .ELEM_W   (ELEM_W),
        .MAC_SIZE (MAC_SIZE)
    ) u_skew_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .in_vec  (a_skew_in),
        .out_vec (a_out)
    );

    skew_delay_line #(
        .ELEM_W   (ELEM_W),
        .MAC_SIZE (MAC_SIZE)
    ) u_skew_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift   (shift),
        .in_vec  (b_skew_in),
        .out_vec (b_out)
    );

endmodule

// File: tb/tb_skewed_operand_feeder.sv
// Directed bench for skewed_operand_feeder with a 4x4 array over an 8x8 product (WPV=1).
module tb_skewed_operand_feeder;

    localparam int B_BASE = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [22:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        out_last;
    logic        copy_enb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] bq_a[$];
    logic [31:0] bq_b[$];
    logic        bq_l[$];
    int          bq_c[$];
    int          rd_q[$];
    int          cp_q[$];
    int          dn_q[$];

    skewed_operand_feeder #(
        .ELEM_W       (8),
        .MAC_SIZE     (4),
        .BIG_MAC_SIZE (8),
        .MEM_DATA_W   (32),
        .ADDR_W       (23),
        .B_BASE_ADDR  (B_BASE),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_last  (out_last),
        .copy_enb  (copy_enb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input int a);
        logic [31:0] w;
        w = {8'(a), 8'(a + 1), 8'(a + 2), 8'(a + 3)};
        if (a >= B_BASE) w = w + 32'h80;
        return w;
    endfunction

    // Beat t, lane i carries element i of vector (t-i) of the region starting at base.
    function automatic logic [31:0] exp_vec(input int base, input int t);
        logic [31:0] v;
        logic [31:0] w;
        int k;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            k = t - i;
            if (k >= 0 && k < 8) begin
                w = memword(base + k);
                v[31-8*i -: 8] = w[31-8*i -: 8];
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem_rd_en ? memword(int'(mem_addr)) : 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                bq_a.push_back(a_out);
                bq_b.push_back(b_out);
                bq_l.push_back(out_last);
                bq_c.push_back(cyc);
            end
            if (mem_rd_en) rd_q.push_back(int'(mem_addr));
            if (copy_enb) cp_q.push_back(cyc);
            if (done) dn_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input string tag, input bit use_done, input int target);
        int n;
        for (int i = 0; i < 400; i++) begin
            n = use_done ? dn_q.size() : cp_q.size();
            if (n >= target) break;
            tick();
        end
        n = use_done ? dn_q.size() : cp_q.size();
        chk(tag, 64'(n >= target), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int b2, c2, b3, r3, c3;
        logic [31:0] ha, hb;

        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ctrl", 64'({busy, done, mem_rd_en, out_valid, out_last, copy_enb}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_a", 64'(a_out), 64'd0);
        chk("rst_b", 64'(b_out), 64'd0);
        rst_n = 1'b1;
        tick();

        // Run 1: full product with ready high, plus stray start pulses while busy.
        pulse_start();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_rd", 64'(mem_rd_en), 64'd1);
        chk("start_addr", 64'(mem_addr), 64'd0);
        repeat (45) tick();
        pulse_start();
        chk("busy_ignore", 64'(busy), 64'd1);
        repeat (60) tick();
        pulse_start();
        wait_count("run1_done", 1'b1, 1);
        repeat (5) tick();
        chk("run1_idle", 64'(busy), 64'd0);
        chk("run1_copies", 64'(cp_q.size()), 64'd4);
        chk("run1_dones", 64'(dn_q.size()), 64'd1);
        chk("done_gap", 64'(dn_q[0] - cp_q[3]), 64'd1);
        chk("run1_beats", 64'(bq_a.size()), 64'd44);
        chk("run1_reads", 64'(rd_q.size()), 64'd64);
        chk("beat0_a", 64'(bq_a[0]), 64'h00000000);
        chk("beat0_b", 64'(bq_b[0]), 64'h40000000);
        chk("beat3_a", 64'(bq_a[3]), 64'h03030303);
        chk("beat3_b", 64'(bq_b[3]), 64'h434343C3);
        chk("beat10_a", 64'(bq_a[10]), 64'h0000000A);
        chk("beat_spacing", 64'(bq_c[1] - bq_c[0]), 64'd4);
        for (int t = 0; t < 11; t++) begin
            chk($sformatf("t00_a%0d", t), 64'(bq_a[t]), 64'(exp_vec(0, t)));
            chk($sformatf("t00_b%0d", t), 64'(bq_b[t]), 64'(exp_vec(B_BASE, t)));
            chk($sformatf("t00_last%0d", t), 64'(bq_l[t]), 64'(t == 10));
        end
        chk("copy_gap", 64'(cp_q[0] - bq_c[10]), 64'd5);
        chk("t01_rdA", 64'(rd_q[16]), 64'd0);
        chk("t01_rdB", 64'(rd_q[17]), 64'd72);
        chk("t10_rdA", 64'(rd_q[32]), 64'd8);
        chk("t10_rdB", 64'(rd_q[33]), 64'd64);
        chk("t11_a3", 64'(bq_a[33 + 3]), 64'h0B0B0B0B);
        chk("t11_b3", 64'(bq_b[33 + 3]), 64'h4B4B4BCB);
        chk("t11_last", 64'(bq_l[43]), 64'd1);

        // Run 2: stall beat 2 for five cycles, then reset in the middle of tile 1.
        b2 = bq_a.size();
        c2 = cp_q.size();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (out_valid && (bq_a.size() - b2 == 2)) break;
            tick();
        end
        chk("stall_reach", 64'(out_valid && (bq_a.size() - b2 == 2)), 64'd1);
        out_ready = 1'b0;
        ha = a_out;
        hb = b_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_a%0d", i), 64'(a_out), 64'(ha));
            chk($sformatf("stall_b%0d", i), 64'(b_out), 64'(hb));
            chk($sformatf("stall_v%0d", i), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        wait_count("run2_copy", 1'b0, c2 + 1);
        chk("run2_beats", 64'(bq_a.size() - b2), 64'd11);
        for (int t = 0; t < 11; t++) begin
            chk($sformatf("stl_a%0d", t), 64'(bq_a[b2 + t]), 64'(exp_vec(0, t)));
            chk($sformatf("stl_b%0d", t), 64'(bq_b[b2 + t]), 64'(exp_vec(B_BASE, t)));
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("t1_issue", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ctrl", 64'({busy, done, mem_rd_en, out_valid, out_last, copy_enb}), 64'd0);
        chk("async_addr", 64'(mem_addr), 64'd0);
        chk("async_a", 64'(a_out), 64'd0);
        chk("async_b", 64'(b_out), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no_resume", 64'({busy, out_valid, mem_rd_en}), 64'd0);

        b3 = bq_a.size();
        r3 = rd_q.size();
        c3 = cp_q.size();
        pulse_start();
        chk("restart_addr", 64'(mem_addr), 64'd0);
        chk("restart_rd", 64'(mem_rd_en), 64'd1);
        wait_count("restart_copy", 1'b0, c3 + 1);
        chk("restart_rdA", 64'(rd_q[r3]), 64'd0);
        chk("restart_rdB", 64'(rd_q[r3 + 1]), 64'd64);
        chk("restart_a3", 64'(bq_a[b3 + 3]), 64'h03030303);
        chk("restart_b3", 64'(bq_b[b3 + 3]), 64'h434343C3);
        wait_count("restart_done", 1'b1, 2);
        chk("restart_copies", 64'(cp_q.size() - c3), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
